// File: rtl/encrypter_arbiter_pkg.sv
// Shared constants and state encoding for the two-channel Encrypter arbiter.
package encrypter_arbiter_pkg;

   localparam int ENCRYPTER_WIDTH    = 16;
   localparam int KEY_ROTATION_WIDTH = 4;
   localparam int NUM_CHANNELS       = 2;

   typedef enum logic [2:0] {
      IDLE,
      PROG,
      FEED,
      HSIN,
      DRAIN,
      RESP
   } state_t;

endpackage

// File: rtl/encrypter_arbiter_rr_pick2.sv
// Combinational round-robin picker for two requesters; a tie goes to the
// channel that did not win last time.
module rr_pick2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_idx
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      grant_valid = |req_valid;
      grant_idx   = 1'b0;
      case (req_valid)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_grant;
         default: grant_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/encrypter_arbiter.sv
// Shares one Encrypter between two requester channels in round-robin bursts,
// reprogramming the key per grant and tagging each ciphertext with its channel.
module encrypter_arbiter
   import encrypter_arbiter_pkg::*;
#(
   parameter int WIDTH     = ENCRYPTER_WIDTH,
   parameter int ROT_W     = KEY_ROTATION_WIDTH,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CHANNELS-1:0]   req_valid,
   input  logic [2*WIDTH-1:0]        req_data,
   input  logic [2*ROT_W-1:0]        req_rot,
   output logic [NUM_CHANNELS-1:0]   req_ready,
   output logic                      rsp_valid,
   output logic [WIDTH-1:0]          rsp_data,
   output logic                      rsp_id,
   input  logic                      rsp_ready,
   output logic [WIDTH-1:0]          enc_dataIn,
   output logic [ROT_W-1:0]          enc_rot_offset,
   output logic                      enc_prog,
   output logic                      enc_rdyIn,
   input  logic                      enc_reqIn,
   input  logic [WIDTH-1:0]          enc_dataOut,
   input  logic                      enc_reqOut,
   output logic                      enc_rdyOut,
   output logic                      busy,
   output logic                      grant_id
);

   localparam logic [4:0] MAX_BURST_W = 5'(MAX_BURST);

   state_t      state, state_nxt;
   logic        last_grant;
   logic [3:0]  burst_cnt;
   logic [4:0]  burst_inc;
   logic        burst_more;
   logic        pick_valid;
   logic        pick_idx;
   logic [WIDTH-1:0] sel_data;
   logic [ROT_W-1:0] pick_rot;

   rr_pick2 u_pick (
      .req_valid   (req_valid),
      .last_grant  (last_grant),
      .grant_valid (pick_valid),
      .grant_idx   (pick_idx)
   );

   assign sel_data   = grant_id ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
   assign pick_rot   = pick_idx ? req_rot[2*ROT_W-1:ROT_W] : req_rot[ROT_W-1:0];
   assign burst_inc  = {1'b0, burst_cnt} + 5'd1;
   assign burst_more = (burst_inc < MAX_BURST_W) && req_valid[grant_id];
   assign busy       = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      enc_prog   = 1'b0;
      enc_rdyOut = 1'b0;
      case (state)
         IDLE:  if (pick_valid) state_nxt = PROG;
         PROG: begin
            enc_prog  = 1'b1;
            state_nxt = FEED;
         end
         FEED: begin
            if (!req_valid[grant_id]) begin
               state_nxt = IDLE;
            end else if (enc_reqIn) begin
               req_ready[grant_id] = 1'b1;
               state_nxt           = HSIN;
            end
         end
         HSIN:  if (!enc_reqIn) state_nxt = DRAIN;
         DRAIN: if (enc_reqOut) state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               enc_rdyOut = 1'b1;
               state_nxt  = burst_more ? FEED : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_id       <= 1'b0;
         last_grant     <= 1'b1;
         burst_cnt      <= '0;
         enc_rot_offset <= '0;
         enc_dataIn     <= '0;
         enc_rdyIn      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_data       <= '0;
         rsp_id         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_id       <= pick_idx;
                  enc_rot_offset <= pick_rot;
                  burst_cnt      <= '0;
               end
            end
            FEED: begin
               if (!req_valid[grant_id]) begin
                  last_grant <= grant_id;
                  burst_cnt  <= '0;
               end else if (enc_reqIn) begin
                  enc_dataIn <= sel_data;
                  enc_rdyIn  <= 1'b1;
               end
            end
            // Four-phase input handshake: release rdyIn only once the Encrypter drops reqIn.
            HSIN: if (!enc_reqIn) enc_rdyIn <= 1'b0;
            DRAIN: begin
               if (enc_reqOut) begin
                  rsp_data  <= enc_dataOut;
                  rsp_id    <= grant_id;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (burst_more) begin
                     burst_cnt <= burst_inc[3:0];
                  end else begin
                     last_grant <= grant_id;
                     burst_cnt  <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_encrypter_arbiter.sv
// Directed bench for encrypter_arbiter with an XOR-key Encrypter stub.
module tb_encrypter_arbiter;
   import encrypter_arbiter_pkg::*;

   localparam int W = 16;
   localparam int R = 4;
   localparam logic [W-1:0] KEY = 16'h3C13;

   logic           clk;
   logic           reset;
   logic [1:0]     req_valid;
   logic [2*W-1:0] req_data;
   logic [2*R-1:0] req_rot;
   logic [1:0]     req_ready;
   logic           rsp_valid;
   logic [W-1:0]   rsp_data;
   logic           rsp_id;
   logic           rsp_ready;
   logic [W-1:0]   enc_dataIn;
   logic [R-1:0]   enc_rot_offset;
   logic           enc_prog;
   logic           enc_rdyIn;
   logic           enc_reqIn;
   logic [W-1:0]   enc_dataOut;
   logic           enc_reqOut;
   logic           enc_rdyOut;
   logic           busy;
   logic           grant_id;

   encrypter_arbiter #(.WIDTH(W), .ROT_W(R), .MAX_BURST(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_rot        (req_rot),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_id         (rsp_id),
      .rsp_ready      (rsp_ready),
      .enc_dataIn     (enc_dataIn),
      .enc_rot_offset (enc_rot_offset),
      .enc_prog       (enc_prog),
      .enc_rdyIn      (enc_rdyIn),
      .enc_reqIn      (enc_reqIn),
      .enc_dataOut    (enc_dataOut),
      .enc_reqOut     (enc_reqOut),
      .enc_rdyOut     (enc_rdyOut),
      .busy           (busy),
      .grant_id       (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Encrypter stub: 4-phase input, then result = dataIn ^ KEY held until rdyOut.
   logic [W-1:0] stub_last_in = '0;
   initial begin
      int phase;
      phase       = 0;
      enc_reqIn   = 1'b0;
      enc_reqOut  = 1'b0;
      enc_dataOut = '0;
      forever begin
         @(posedge clk); #2;
         if (!reset) begin
            phase      = 0;
            enc_reqIn  = 1'b1;
            enc_reqOut = 1'b0;
         end else begin
            case (phase)
               0: if (enc_rdyIn) begin
                  stub_last_in = enc_dataIn;
                  enc_reqIn    = 1'b0;
                  phase        = 1;
               end
               1: begin
                  enc_dataOut = stub_last_in ^ KEY;
                  enc_reqOut  = 1'b1;
                  phase       = 2;
               end
               default: if (enc_rdyOut) begin
                  enc_reqOut = 1'b0;
                  enc_reqIn  = 1'b1;
                  phase      = 0;
               end
            endcase
         end
      end
   end

   // Protocol monitor: prog width, rot stability, req_ready exclusivity, rdyOut count.
   int           prog_cnt   = 0;
   int           rdyout_cnt = 0;
   logic [R-1:0] prog_rots[$];
   logic [R-1:0] cur_rot    = '0;
   logic         prev_prog  = 1'b0;
   logic         prev_rr    = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         if (enc_prog) begin
            prog_cnt++;
            prog_rots.push_back(enc_rot_offset);
            cur_rot = enc_rot_offset;
            check("prog_one_cycle", 32'(prev_prog), 32'(0));
         end else if (busy) begin
            check("rot_stable", 32'(enc_rot_offset), 32'(cur_rot));
         end
         if (req_ready != 2'b00)
            check("req_ready_exclusive", 32'((req_ready == 2'b11) || rsp_valid || prev_rr), 32'(0));
         if (enc_rdyOut) rdyout_cnt++;
      end
      prev_prog = enc_prog;
      prev_rr   = |req_ready;
   end

   typedef struct {
      logic         id;
      logic [W-1:0] data;
   } rsp_t;
   rsp_t exp_q[$];

   // Runs until all expected responses arrive; drops a channel's valid after lim accepts.
   task automatic run_stream(input int lim0, input int lim1, input int timeout);
      int   acc0 = 0;
      int   acc1 = 0;
      rsp_t e;
      for (int cyc = 0; cyc < timeout && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (req_ready[0]) acc0++;
         if (req_ready[1]) acc1++;
         if (rsp_valid && rsp_ready) begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
         end
         @(posedge clk); #1;
         if (acc0 >= lim0) req_valid[0] = 1'b0;
         if (acc1 >= lim1) req_valid[1] = 1'b0;
      end
      if (exp_q.size() != 0) begin
         check("stream_timeout_left", 32'(exp_q.size()), 32'(0));
         exp_q.delete();
      end
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("idle_reached", 32'(busy), 32'(0));
   endtask

   task automatic push_exp(input logic id, input logic [W-1:0] data, input int n);
      rsp_t e;
      e.id   = id;
      e.data = data;
      for (int k = 0; k < n; k++) exp_q.push_back(e);
   endtask

   typedef struct {
      logic         ch;
      logic [W-1:0] data;
      logic [R-1:0] rot;
      logic [W-1:0] exp_data;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int   p0;
      int   r0;
      logic seen;
      logic [W-1:0] held;

      vecs[0] = '{1'b0, 16'hCCE3, 4'h7, 16'hF0F0};
      vecs[1] = '{1'b1, 16'h1234, 4'hA, 16'h2E27};
      vecs[2] = '{1'b0, 16'hFFFF, 4'h0, 16'hC3EC};
      vecs[3] = '{1'b1, 16'h0000, 4'hF, 16'h3C13};
      vecs[4] = '{1'b0, 16'hA5A5, 4'h3, 16'h99B6};

      reset     = 1'b0;
      req_valid = 2'b00;
      req_data  = '0;
      req_rot   = '0;
      rsp_ready = 1'b1;

      // Reset state
      #15;
      check("reset_data", {rsp_data, enc_dataIn}, 32'(0));
      check("reset_ctrl", 32'({req_ready, rsp_valid, rsp_id, enc_rot_offset, enc_prog,
                               enc_rdyIn, enc_rdyOut, busy, grant_id}), 32'(0));
      #5 reset = 1'b1;
      @(negedge clk); @(negedge clk);
      check("post_reset_idle", 32'({busy, enc_prog, req_ready, rsp_valid}), 32'(0));

      // Single-word transactions from the vector table
      foreach (vecs[i]) begin
         p0 = prog_cnt;
         @(posedge clk); #1;
         if (vecs[i].ch) begin
            req_data[2*W-1:W] = vecs[i].data;
            req_rot[2*R-1:R]  = vecs[i].rot;
            req_valid         = 2'b10;
         end else begin
            req_data[W-1:0] = vecs[i].data;
            req_rot[R-1:0]  = vecs[i].rot;
            req_valid       = 2'b01;
         end
         push_exp(vecs[i].ch, vecs[i].exp_data, 1);
         run_stream(1, 1, 200);
         wait_idle();
         check("vec_prog_cnt", 32'(prog_cnt - p0), 32'(1));
         check("vec_rot", 32'(prog_rots[$]), 32'(vecs[i].rot));
         check("vec_dataIn", 32'(stub_last_in), 32'(vecs[i].data));
      end

      // Backpressure: hold rsp_ready low for 5 cycles in RESP
      @(posedge clk); #1;
      rsp_ready         = 1'b0;
      req_data[2*W-1:W] = 16'h4321;
      req_rot[2*R-1:R]  = 4'h1;
      req_valid         = 2'b10;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = req_ready[1];
      end
      check("bp_req_ready_seen", 32'(seen), 32'(1));
      @(posedge clk); #1;
      req_valid = 2'b00;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      check("bp_rsp_seen", 32'(seen), 32'(1));
      check("bp_rsp_data", 32'(rsp_data), 32'(16'h7F32));
      check("bp_rsp_id", 32'(rsp_id), 32'(1));
      held = 16'h7F32;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_hold", 32'({rsp_valid, rsp_data, enc_rdyOut, req_ready}),
               32'({1'b1, held, 1'b0, 2'b00}));
      end
      r0 = rdyout_cnt;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_rdyout_pulse", 32'(enc_rdyOut), 32'(1));
      @(negedge clk);
      check("bp_after", 32'({enc_rdyOut, rsp_valid}), 32'(0));
      wait_idle();
      check("bp_rdyout_count", 32'(rdyout_cnt - r0), 32'(1));

      // Withdrawal: channel 0 stops after 2 words, channel 1 then granted
      p0 = prog_cnt;
      @(posedge clk); #1;
      req_data  = {16'hF00F, 16'h0F0F};
      req_rot   = {4'hC, 4'h2};
      req_valid = 2'b11;
      push_exp(1'b0, 16'h331C, 2);
      push_exp(1'b1, 16'hCC1C, 2);
      run_stream(2, 2, 400);
      wait_idle();
      check("wd_prog_cnt", 32'(prog_cnt - p0), 32'(2));
      check("wd_rot0", 32'(prog_rots[p0]), 32'(4'h2));
      check("wd_rot1", 32'(prog_rots[p0+1]), 32'(4'hC));

      // Reset while in HSIN aborts immediately
      p0 = prog_cnt;
      @(posedge clk); #1;
      req_data[W-1:0] = 16'h5A5A;
      req_valid       = 2'b01;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = enc_rdyIn;
      end
      check("mid_hsin_seen", 32'(seen), 32'(1));
      #1 reset = 1'b0;
      req_valid = 2'b00;
      #1;
      check("mid_reset_async", 32'({enc_rdyIn, busy, rsp_valid, req_ready}), 32'(0));
      @(posedge clk);
      @(posedge clk); #3;
      reset = 1'b1;
      check("mid_prog_cnt", 32'(prog_cnt - p0), 32'(1));

      // Tie and fairness right after reset: channel 0 first, bursts of 4
      p0 = prog_cnt;
      @(posedge clk); #1;
      req_data  = {16'h2222, 16'h1111};
      req_rot   = {4'h9, 4'h5};
      req_valid = 2'b11;
      push_exp(1'b0, 16'h2D02, 4);
      push_exp(1'b1, 16'h1E31, 4);
      push_exp(1'b0, 16'h2D02, 4);
      run_stream(8, 4, 1000);
      wait_idle();
      check("fair_prog_cnt", 32'(prog_cnt - p0), 32'(3));
      check("fair_rot0", 32'(prog_rots[p0]), 32'(4'h5));
      check("fair_rot1", 32'(prog_rots[p0+1]), 32'(4'h9));
      check("fair_rot2", 32'(prog_rots[p0+2]), 32'(4'h5));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/encrypter_arbiter.md
Name: encrypter_arbiter

Overview:
- Shares one Encrypter instance between two requester channels using round-robin bursts.
- Per grant: latches the winner's rot_offset, pulses prog to reprogram the key, then streams up to MAX_BURST words through the Encrypter's reqIn/rdyIn and reqOut/rdyOut handshakes.
- Returns each ciphertext word tagged with the channel id.
- Sits between the host-side requesters and the Encrypter datapath.

Parameters:
- WIDTH, 16 (`ENCRYPTER_WIDTH): data word width.
- ROT_W, 4 (`KEY_ROTATION_WIDTH): key rotation offset width.
- MAX_BURST, 4: maximum words per grant before re-arbitration, range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-channel word available.
- req_data  in  2*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- req_rot  in  2*ROT_W  per-channel rotation offset, sampled at grant only.
- req_ready  out  2  one-cycle accept pulse to the granted channel.
- rsp_valid  out  1  ciphertext word available.
- rsp_data  out  WIDTH  ciphertext word.
- rsp_id  out  1  channel that owns rsp_data.
- rsp_ready  in  1  consumer accepts the response.
- enc_dataIn  out  WIDTH  to Encrypter dataIn.
- enc_rot_offset  out  ROT_W  to Encrypter rot_offset.
- enc_prog  out  1  one-cycle key reprogram strobe.
- enc_rdyIn  out  1  input-data-ready to Encrypter.
- enc_reqIn  in  1  Encrypter requests input.
- enc_dataOut  in  WIDTH  Encrypter result.
- enc_reqOut  in  1  Encrypter result valid.
- enc_rdyOut  out  1  result-consumed acknowledge to Encrypter.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  current or last granted channel.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; last_grant=1, so channel 0 wins the first tie; burst_cnt=0.
- FSM states: IDLE, PROG, FEED, HSIN, DRAIN, RESP.
- IDLE:
  - If exactly one req_valid bit is set, grant that channel.
  - If both are set, grant ~last_grant.
  - On grant: latch grant_id and enc_rot_offset <= req_rot[grant], then go to PROG.
  - Grant-to-prog latency: 1 cycle.
- PROG: enc_prog=1 for exactly one cycle, then go to FEED. enc_rot_offset is held stable for the whole grant.
- FEED:
  - If req_valid[g]=0, end the burst: last_grant<=g, go to IDLE.
  - Else, when enc_reqIn=1: enc_dataIn<=req_data[g], enc_rdyIn<=1, req_ready[g]=1 for one cycle, go to HSIN.
  - If enc_reqIn=0, wait.
- HSIN: hold enc_rdyIn=1 and enc_dataIn stable until enc_reqIn=0 (4-phase). Then enc_rdyIn<=0 and go to DRAIN.
- DRAIN: when enc_reqOut=1, capture rsp_data<=enc_dataOut, rsp_id<=g, rsp_valid<=1, then go to RESP.
- RESP:
  - Hold rsp_valid and rsp_data stable until rsp_ready=1.
  - On the accept cycle: rsp_valid<=0, enc_rdyOut=1 for one cycle, burst_cnt<=burst_cnt+1.
  - If burst_cnt+1 < MAX_BURST and req_valid[g]: go to FEED without reprogramming.
  - Otherwise: last_grant<=g, burst_cnt<=0, go to IDLE.
- Backpressure: rsp_ready low stalls in RESP indefinitely. No new input is fed while a result is pending; one word is in flight at most.
- Simultaneous events:
  - A req_rot change mid-burst is ignored.
  - The non-granted channel's req_valid has no effect until IDLE.
  - enc_reqIn high while in DRAIN or RESP is ignored.
- Reset mid-operation: aborts immediately. No req_ready or rsp_valid is issued for the in-flight word, and the burst is lost.
- req_ready is never asserted to the non-granted channel. req_ready and rsp_valid never assert in the same cycle for different words.

Decomposition:
- Shared constants package/header: `ENCRYPTER_WIDTH, `KEY_ROTATION_WIDTH, the state encoding enum (IDLE..RESP), and the channel-count constant (2).
- One sub-module, rr_pick2: combinational round-robin picker with inputs req_valid[1:0] and last_grant, outputs grant_valid and grant_idx. It is instantiated once in IDLE decode.
- Remaining logic (FSM, latches, burst counter) stays in encrypter_arbiter.

Test Plan:
- Reset: hold reset=0 for 20ns, then release → all outputs 0, busy=0, and after 1 cycle still IDLE with no req_valid.
- Single channel: req_valid=2'b01, req_data[15:0]=16'hCCE3, req_rot[3:0]=4'h7 → one-cycle enc_prog pulse with enc_rot_offset=4'h7. On enc_reqIn, enc_dataIn=16'hCCE3 and req_ready=2'b01 for one cycle. A stub enc_dataOut=16'hF0F0 yields rsp_data=16'hF0F0, rsp_id=0.
- Tie and fairness: both channels valid continuously, MAX_BURST=4 → 4 responses with rsp_id=0, a new enc_prog pulse, then 4 with rsp_id=1, alternating. enc_rot_offset follows each channel's req_rot.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_data stable, enc_rdyOut=0, no req_ready. enc_rdyOut pulses exactly once after rsp_ready rises.
- Withdrawal: channel 0 drops req_valid after 2 words in its burst → return to IDLE, channel 1 granted next with a fresh enc_prog pulse.
- Reset mid-burst: assert reset while in HSIN → enc_rdyIn, busy, and rsp_valid go to 0 without waiting for a clock edge. After release, channel 0 is granted first again.
